ts_null_stuffer: RTL and testbench

Output pacing stage that sits directly downstream of the TS channel multiplexer on `payload_clk`. It buffers complete 188-byte transport packets (47 × 32-bit words) from the multiplexer's bursty output and emits exactly one packet per output slot tick. When no buffered packet is available at a tick, it emits a null packet (PID 0x1FFF), so the downstream modulator/serializer sees a constant packet rate. Malformed and overflowing packets are dropped whole, never truncated.

---
 rtl/ts_null_stuffer_if.sv | 20 ++
 rtl/ts_null_stuffer.sv | 207 ++++++++++++++++++++
 tb/tb_ts_null_stuffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_null_stuffer_if.sv
// Word-stream bundle for the null stuffer: bursty packet input and paced packet output.
interface ts_null_stuffer_if;
  logic        payload_in_valid;
  logic [31:0] payload_in_data;
  logic        payload_in_start;
  logic        payload_in_end;
  logic        payload_out_valid;
  logic [31:0] payload_out_data;
  logic        payload_out_start;
  logic        payload_out_end;

  modport master (
    output payload_in_valid, payload_in_data, payload_in_start, payload_in_end,
    input  payload_out_valid, payload_out_data, payload_out_start, payload_out_end
  );
  modport slave (
    input  payload_in_valid, payload_in_data, payload_in_start, payload_in_end,
    output payload_out_valid, payload_out_data, payload_out_start, payload_out_end
  );
endinterface

// File: rtl/ts_null_stuffer.sv
// Buffers whole TS packets and emits exactly one packet per slot tick,
// substituting a null packet when nothing is buffered.
module ts_null_stuffer #(
  parameter int          PKT_WORDS  = 47,
  parameter int          FIFO_PKTS  = 4,
  parameter logic [31:0] NULL_WORD0 = 32'h471FFF10,
  parameter logic [31:0] NULL_FILL  = 32'hFFFFFFFF
) (
  input  logic                payload_clk,
  input  logic                payload_rst_n,
  ts_null_stuffer_if.slave    bus,
  input  logic                slot_tick,
  output logic [15:0]         pkt_count,
  output logic [15:0]         null_count,
  output logic [15:0]         drop_count,
  output logic                buffer_overflow
);
  localparam int DEPTH = FIFO_PKTS * PKT_WORDS;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = $clog2(FIFO_PKTS);
  localparam int OW    = $clog2(PKT_WORDS + 1);
  localparam int CW    = $clog2(FIFO_PKTS + 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP} wr_st_e;
  typedef enum logic [1:0] {R_IDLE, R_PREP, R_DATA, R_NULL} rd_st_e;
  typedef struct packed {
    logic        valid;
    logic        start;
    logic        last;
    logic [31:0] data;
  } out_t;

  function automatic logic [SW-1:0] nxt_slot(input logic [SW-1:0] s);
    return (s == SW'(FIFO_PKTS - 1)) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [31:0] ram [DEPTH];

  wr_st_e        wst_q, wst_d;
  rd_st_e        rst_q, rst_d;
  logic [OW-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic [SW-1:0] wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [CW-1:0] stored_q, stored_d;
  logic [15:0]   pkt_q, pkt_d, null_q, null_d, drop_q, drop_d;
  logic          ovf_q, ovf_d;
  out_t          out_q, out_d;

  logic          we, commit, release_pkt;
  logic [AW-1:0] wa, ra;
  logic [1:0]    drop_inc;

  always_comb begin
    wst_d     = wst_q;
    wr_off_d  = wr_off_q;
    wr_slot_d = wr_slot_q;
    we        = 1'b0;
    commit    = 1'b0;
    drop_inc  = 2'd0;
    ovf_d     = 1'b0;
    wa        = AW'(int'(wr_slot_q) * PKT_WORDS + int'(wr_off_q));
    if (bus.payload_in_valid) begin
      if (bus.payload_in_start) begin
        // A start always reopens the current slot at offset 0; any partial packet is lost.
        if (wst_q == W_FILL) drop_inc = drop_inc + 2'd1;
        wa = AW'(int'(wr_slot_q) * PKT_WORDS);
        if (bus.payload_in_end) begin
          drop_inc = drop_inc + 2'd1;
          wst_d    = W_IDLE;
        end else if (stored_q < CW'(FIFO_PKTS)) begin
          we       = 1'b1;
          wr_off_d = OW'(1);
          wst_d    = W_FILL;
        end else begin
          ovf_d    = 1'b1;
          drop_inc = drop_inc + 2'd1;
          wst_d    = W_SKIP;
        end
      end else if (wst_q == W_FILL) begin
        if (wr_off_q == OW'(PKT_WORDS)) begin
          drop_inc = 2'd1;
          wst_d    = W_IDLE;
        end else if (bus.payload_in_end) begin
          wst_d = W_IDLE;
          if (wr_off_q == OW'(PKT_WORDS - 1)) begin
            we        = 1'b1;
            commit    = 1'b1;
            wr_slot_d = nxt_slot(wr_slot_q);
          end else begin
            drop_inc = 2'd1;
          end
        end else begin
          we       = 1'b1;
          wr_off_d = wr_off_q + 1'b1;
        end
      end else if (wst_q == W_SKIP && bus.payload_in_end) begin
        wst_d = W_IDLE;
      end
    end
  end

  always_comb begin
    rst_d       = rst_q;
    rd_off_d    = rd_off_q;
    rd_slot_d   = rd_slot_q;
    release_pkt = 1'b0;
    pkt_d       = pkt_q;
    null_d      = null_q;
    out_d       = '0;
    ra          = AW'(int'(rd_slot_q) * PKT_WORDS + int'(rd_off_q));
    case (rst_q)
      R_IDLE: begin
        // Holding off while the end word is on the output guarantees an idle gap between packets.
        if (slot_tick && !out_q.last) begin
          rd_off_d = '0;
          rst_d    = (stored_q != '0) ? R_PREP : R_NULL;
        end
      end
      R_PREP: begin
        out_d    = '{valid: 1'b1, start: 1'b1, last: 1'b0, data: ram[ra]};
        rd_off_d = OW'(1);
        rst_d    = R_DATA;
      end
      R_DATA: begin
        out_d.valid = 1'b1;
        out_d.data  = ram[ra];
        if (rd_off_q == OW'(PKT_WORDS - 1)) begin
          out_d.last  = 1'b1;
          release_pkt = 1'b1;
          rd_slot_d   = nxt_slot(rd_slot_q);
          pkt_d       = sat_add(pkt_q, 2'd1);
          rst_d       = R_IDLE;
        end else begin
          rd_off_d = rd_off_q + 1'b1;
        end
      end
      R_NULL: begin
        out_d.valid = 1'b1;
        out_d.start = (rd_off_q == '0);
        out_d.data  = (rd_off_q == '0) ? NULL_WORD0 : NULL_FILL;
        if (rd_off_q == OW'(PKT_WORDS - 1)) begin
          out_d.last = 1'b1;
          null_d     = sat_add(null_q, 2'd1);
          rst_d      = R_IDLE;
        end else begin
          rd_off_d = rd_off_q + 1'b1;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    drop_d   = sat_add(drop_q, drop_inc);
    stored_d = stored_q;
    if (commit && !release_pkt) stored_d = stored_q + 1'b1;
    else if (!commit && release_pkt) stored_d = stored_q - 1'b1;
  end

  always_ff @(posedge payload_clk) begin
    if (we) ram[wa] <= bus.payload_in_data;
  end

  always_ff @(posedge payload_clk or negedge payload_rst_n) begin
    if (!payload_rst_n) begin
      wst_q     <= W_IDLE;
      rst_q     <= R_IDLE;
      wr_off_q  <= '0;
      rd_off_q  <= '0;
      wr_slot_q <= '0;
      rd_slot_q <= '0;
      stored_q  <= '0;
      pkt_q     <= '0;
      null_q    <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
    end else begin
      wst_q     <= wst_d;
      rst_q     <= rst_d;
      wr_off_q  <= wr_off_d;
      rd_off_q  <= rd_off_d;
      wr_slot_q <= wr_slot_d;
      rd_slot_q <= rd_slot_d;
      stored_q  <= stored_d;
      pkt_q     <= pkt_d;
      null_q    <= null_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
    end
  end

  assign bus.payload_out_valid = out_q.valid;
  assign bus.payload_out_start = out_q.start;
  assign bus.payload_out_end   = out_q.last;
  assign bus.payload_out_data  = out_q.data;
  assign pkt_count             = pkt_q;
  assign null_count            = null_q;
  assign drop_count            = drop_q;
  assign buffer_overflow       = ovf_q;
endmodule

// File: tb/tb_ts_null_stuffer.sv
// Random and directed stimulus for ts_null_stuffer, checked every cycle against a
// packet-level queue model plus a few literal expectations.
module tb_ts_null_stuffer;
  localparam int PW = 47;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slot_tick = 1'b0;
  logic [15:0] pkt_count, null_count, drop_count;
  logic        buffer_overflow;

  ts_null_stuffer_if bus_if();

  ts_null_stuffer #(.PKT_WORDS(PW), .FIFO_PKTS(NP)) dut (
    .payload_clk     (clk),
    .payload_rst_n   (rst_n),
    .bus             (bus_if),
    .slot_tick       (slot_tick),
    .pkt_count       (pkt_count),
    .null_count      (null_count),
    .drop_count      (drop_count),
    .buffer_overflow (buffer_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    bit          s;
    bit          e;
    bit          n;
    logic [31:0] d;
  } ow_t;

  ow_t         stream[$];     // outputs for coming cycles
  ow_t         cur_o;         // output expected in the current cycle
  logic [31:0] fifo_w[$];     // committed packets, PW words each
  logic [31:0] cur_pkt[$];    // packet being collected
  int          wmode;         // 0 idle, 1 collecting, 2 skipping
  int          inflight;      // packet being sent, still occupying its slot
  int          m_pkt, m_null, m_drop;
  bit          m_ovf;

  function automatic logic [15:0] sat16(input int x);
    return (x > 65535) ? 16'hFFFF : 16'(x);
  endfunction

  function automatic ow_t idle_w();
    ow_t w;
    w.v = 0; w.s = 0; w.e = 0; w.n = 0; w.d = '0;
    return w;
  endfunction

  task automatic model_reset();
    stream.delete(); fifo_w.delete(); cur_pkt.delete();
    cur_o = idle_w();
    wmode = 0; inflight = 0; m_pkt = 0; m_null = 0; m_drop = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int  stored_now;
    ow_t w;
    if (!rst_n) begin model_reset(); return; end
    stored_now = fifo_w.size() / PW + inflight;
    // read side: one packet per accepted tick, first word two cycles later
    if (slot_tick && stream.size() == 0 && !cur_o.v) begin
      stream.push_back(idle_w());
      for (int i = 0; i < PW; i++) begin
        w.v = 1; w.s = (i == 0); w.e = (i == PW - 1);
        if (fifo_w.size() > 0 && (i > 0 || fifo_w.size() >= PW) && (inflight == 1 || i == 0)) begin
          w.n = 0; w.d = fifo_w.pop_front(); inflight = 1;
        end else begin
          w.n = 1; w.d = (i == 0) ? 32'h471FFF10 : 32'hFFFFFFFF;
        end
        stream.push_back(w);
      end
    end
    cur_o = (stream.size() > 0) ? stream.pop_front() : idle_w();
    if (cur_o.e) begin
      if (cur_o.n) m_null++;
      else begin m_pkt++; inflight = 0; end
    end
    // write side at packet granularity
    m_ovf = 0;
    if (bus_if.payload_in_valid) begin
      if (bus_if.payload_in_start) begin
        if (wmode == 1) m_drop++;
        cur_pkt.delete();
        if (bus_if.payload_in_end) begin m_drop++; wmode = 0; end
        else if (stored_now < NP) begin cur_pkt.push_back(bus_if.payload_in_data); wmode = 1; end
        else begin m_ovf = 1; m_drop++; wmode = 2; end
      end else if (wmode == 1) begin
        if (cur_pkt.size() == PW) begin m_drop++; wmode = 0; end
        else begin
          cur_pkt.push_back(bus_if.payload_in_data);
          if (bus_if.payload_in_end) begin
            if (cur_pkt.size() == PW) foreach (cur_pkt[i]) fifo_w.push_back(cur_pkt[i]);
            else m_drop++;
            wmode = 0;
          end
        end
      end else if (wmode == 2 && bus_if.payload_in_end) begin
        wmode = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin @(posedge clk); model_step(); end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", {31'b0, bus_if.payload_out_valid}, {31'b0, cur_o.v});
      chk("out_start", {31'b0, bus_if.payload_out_start}, {31'b0, cur_o.s});
      chk("out_end", {31'b0, bus_if.payload_out_end}, {31'b0, cur_o.e});
      if (cur_o.v) chk("out_data", bus_if.payload_out_data, cur_o.d);
      chk("pkt_count", {16'b0, pkt_count}, {16'b0, sat16(m_pkt)});
      chk("null_count", {16'b0, null_count}, {16'b0, sat16(m_null)});
      chk("drop_count", {16'b0, drop_count}, {16'b0, sat16(m_drop)});
      chk("buffer_overflow", {31'b0, buffer_overflow}, {31'b0, m_ovf});
      if (buffer_overflow === 1'b1) ovf_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_words(input int n, input logic [31:0] base, input bit do_end, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(negedge clk);
        bus_if.payload_in_valid = 0; bus_if.payload_in_start = 0; bus_if.payload_in_end = 0;
      end
      @(negedge clk);
      bus_if.payload_in_valid = 1;
      bus_if.payload_in_data  = base + 32'(i);
      bus_if.payload_in_start = (i == 0);
      bus_if.payload_in_end   = do_end && (i == n - 1);
    end
    @(negedge clk);
    bus_if.payload_in_valid = 0; bus_if.payload_in_start = 0; bus_if.payload_in_end = 0;
  endtask

  task automatic tick_pulse(input int spacing);
    @(negedge clk); slot_tick = 1;
    @(negedge clk); slot_tick = 0;
    repeat (spacing - 2) @(negedge clk);
  endtask

  initial begin
    bus_if.payload_in_valid = 0; bus_if.payload_in_start = 0;
    bus_if.payload_in_end = 0; bus_if.payload_in_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'b0, bus_if.payload_out_valid}, 32'd0);
    chk("reset_null_count", {16'b0, null_count}, 32'd0);
    rst_n = 1;
    repeat (3) @(negedge clk);

    // 1: empty buffer -> null packet, start word two cycles after the tick
    slot_tick = 1;
    @(negedge clk); slot_tick = 0;
    chk("t1_idle_after_tick", {31'b0, bus_if.payload_out_valid}, 32'd0);
    @(negedge clk);
    chk("t1_first_start", {31'b0, bus_if.payload_out_start}, 32'd1);
    chk("t1_first_word", bus_if.payload_out_data, 32'h471FFF10);
    @(negedge clk);
    chk("t1_fill_word", bus_if.payload_out_data, 32'hFFFFFFFF);
    repeat (45) @(negedge clk);
    chk("t1_end", {31'b0, bus_if.payload_out_end}, 32'd1);
    chk("t1_null_count", {16'b0, null_count}, 32'd1);
    repeat (5) @(negedge clk);

    // 2: one data packet, data = index
    send_words(PW, 32'd0, 1, 0);
    tick_pulse(60);
    chk("t2_pkt_count", {16'b0, pkt_count}, 32'd1);

    // 3: five packets into a four-deep buffer, then five ticks
    for (int p = 0; p < 5; p++) send_words(PW, 32'h1000 * (p + 1), 1, 0);
    repeat (3) @(negedge clk);
    chk("t3_drop_count", {16'b0, drop_count}, 32'd1);
    chk("t3_overflow_pulses", ovf_seen, 32'd1);
    for (int p = 0; p < 5; p++) tick_pulse(60);
    chk("t3_pkt_count", {16'b0, pkt_count}, 32'd5);
    chk("t3_null_count", {16'b0, null_count}, 32'd2);

    // 4: early end, then interrupted packet, then a good one
    send_words(40, 32'h2000, 1, 0);
    send_words(20, 32'h3000, 0, 0);
    send_words(PW, 32'h4000, 1, 0);
    tick_pulse(60);
    chk("t4_drop_count", {16'b0, drop_count}, 32'd3);
    chk("t4_pkt_count", {16'b0, pkt_count}, 32'd6);

    // 5: ticks every 10 cycles while sending
    send_words(PW, 32'h5000, 1, 0);
    send_words(PW, 32'h6000, 1, 0);
    fork
      for (int k = 0; k < 15; k++) tick_pulse(10);
      begin repeat (20) @(negedge clk); send_words(PW, 32'h7000, 1, 0); end
    join
    repeat (60) @(negedge clk);
    chk("t5_pkt_count", {16'b0, pkt_count}, 32'd9);
    chk("t5_null_count", {16'b0, null_count}, 32'd2);

    // 6: commit lands on the release cycle of the packet being sent
    send_words(PW, 32'h8000, 1, 0);
    @(negedge clk); slot_tick = 1;
    fork
      begin @(negedge clk); slot_tick = 0; end
      send_words(PW, 32'h9000, 1, 0);
    join
    repeat (20) @(negedge clk);
    tick_pulse(60);
    chk("t6_pkt_count", {16'b0, pkt_count}, 32'd11);
    tick_pulse(20);
    #1 rst_n = 0;
    #1;
    chk("t6_rst_valid", {31'b0, bus_if.payload_out_valid}, 32'd0);
    chk("t6_rst_data", bus_if.payload_out_data, 32'd0);
    chk("t6_rst_pkt_count", {16'b0, pkt_count}, 32'd0);
    chk("t6_rst_null_count", {16'b0, null_count}, 32'd0);
    chk("t6_rst_drop_count", {16'b0, drop_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);

    // random phase: mixed good/bad packets with random gaps and ticks
    fork
      for (int p = 0; p < 40; p++) begin
        int kind;
        kind = $urandom_range(9);
        case (kind)
          0: send_words(40, $urandom, 1, 20);
          1: send_words(20, $urandom, 0, 20);
          2: send_words(PW + 1, $urandom, 1, 20);
          3: send_words(1, $urandom, 1, 0);
          default: send_words(PW, $urandom, 1, 20);
        endcase
        repeat ($urandom_range(30)) @(negedge clk);
      end
      for (int k = 0; k < 50; k++) tick_pulse($urandom_range(5, 70));
    join
    repeat (200) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
